// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master = upstream/downstream side, slave = the subtractor itself.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one difference bit per cycle, LSB first,
// through a single registered borrow; result and flags are registered on the last bit.
//   state  | meaning
//   S_IDLE | waiting for operands, in_ready=1
//   S_BUSY | shifting one bit per cycle through the borrow stage
//   S_DONE | result presented, out_valid=1 until out_ready
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_amsb;
    logic             r_bmsb;

    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    assign w_accept   = (r_state == S_IDLE) && bus.in_valid && !i_rst;
    assign w_last     = (r_state == S_BUSY) && (r_cnt == CW'(WIDTH - 1));
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_next = S_BUSY;
            S_BUSY:  if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE) && !i_rst;
        bus.out_valid = (r_state == S_DONE);
    end

    // Datapath: the result register only updates on the final bit, so it holds in IDLE/BUSY.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_amsb   <= 1'b0;
            r_bmsb   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= bus.a;
                r_b    <= bus.b;
                r_res  <= '0;
                r_br   <= 1'b0;
                r_cnt  <= '0;
                r_amsb <= bus.a[WIDTH-1];
                r_bmsb <= bus.b[WIDTH-1];
            end else if (r_state == S_BUSY) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= w_res_next;
                r_br  <= w_br_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_diff   <= w_res_next;
                    r_borrow <= w_br_next;
                    r_ovf    <= (r_amsb != r_bmsb) && (w_res_next[WIDTH-1] != r_amsb);
                    r_zero   <= (w_res_next == '0);
                end
            end
        end
    end

    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow;
    assign bus.overflow   = r_ovf;
    assign bus.zero       = r_zero;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors, backpressure,
// mid-operation reset and a run of back-to-back random operations.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bor;
        logic         ovf;
        logic         zero;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bor;
        logic         ovf;
        logic         zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.diff = a - b;
        e.bor  = (a < b);
        e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
        e.zero = (e.diff == '0);
        return e;
    endfunction

    // Monitor: pops one expectation per completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_result: got diff 0x%0h with empty scoreboard", bus.diff);
                end else begin
                    e = sb.pop_front();
                    chk("diff",     64'(bus.diff),       64'(e.diff));
                    chk("borrow",   64'(bus.borrow_out), 64'(e.bor));
                    chk("overflow", 64'(bus.overflow),   64'(e.ovf));
                    chk("zero",     64'(bus.zero),       64'(e.zero));
                end
            end
        end
    end

    int last_acc = 0;

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input exp_t e);
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL in_ready_timeout: in_ready=%0b expected 1 within 200 cycles", bus.in_ready);
            return;
        end
        if (push) sb.push_back(e);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        last_acc     = cyc;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("wait_idle", 64'(bus.in_ready), 64'(1));
    endtask

    vec_t dir[6];

    initial begin
        int   edges;
        int   prev;
        int   bad_gap;
        int   waited;
        exp_t e;
        logic [W-1:0] ra, rb;

        dir[0] = '{a: 8'h5A, b: 8'h1C, diff: 8'h3E, bor: 1'b0, ovf: 1'b0, zero: 1'b0};
        dir[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, bor: 1'b1, ovf: 1'b0, zero: 1'b0};
        dir[2] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bor: 1'b0, ovf: 1'b1, zero: 1'b0};
        dir[3] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, bor: 1'b1, ovf: 1'b1, zero: 1'b0};
        dir[4] = '{a: 8'h37, b: 8'h37, diff: 8'h00, bor: 1'b0, ovf: 1'b0, zero: 1'b1};
        dir[5] = '{a: 8'h80, b: 8'h7F, diff: 8'h01, bor: 1'b0, ovf: 1'b1, zero: 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),   64'(0));
        chk("rst_out_valid", 64'(bus.out_valid),  64'(0));
        chk("rst_diff",      64'(bus.diff),       64'(0));
        chk("rst_borrow",    64'(bus.borrow_out), 64'(0));
        chk("rst_overflow",  64'(bus.overflow),   64'(0));
        chk("rst_zero",      64'(bus.zero),       64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // First op with latency measurement (edges counted including the accept edge)
        issue(dir[0].a, dir[0].b, 1'b1,
              '{diff: dir[0].diff, bor: dir[0].bor, ovf: dir[0].ovf, zero: dir[0].zero});
        edges = 1;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            edges++;
        end
        chk("latency_edges", 64'(edges), 64'(W + 1));

        for (int i = 1; i < 6; i++)
            issue(dir[i].a, dir[i].b, 1'b1,
                  '{diff: dir[i].diff, bor: dir[i].bor, ovf: dir[i].ovf, zero: dir[i].zero});

        // Backpressure: 0xC3 - 0x3C = 0x87, no borrow, no overflow
        wait_idle();
        bus.out_ready = 1'b0;
        issue(8'hC3, 8'h3C, 1'b1, '{diff: 8'h87, bor: 1'b0, ovf: 1'b0, zero: 1'b0});
        waited = 0;
        @(negedge clk);
        while (!bus.out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("bp_valid_seen", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid),  64'(1));
            chk("bp_in_ready",  64'(bus.in_ready),   64'(0));
            chk("bp_diff",      64'(bus.diff),       64'(8'h87));
            chk("bp_borrow",    64'(bus.borrow_out), 64'(0));
            chk("bp_overflow",  64'(bus.overflow),   64'(0));
            chk("bp_zero",      64'(bus.zero),       64'(0));
            bus.in_valid = 1'b1;
            bus.a        = 8'h11;
            bus.b        = 8'h22;
        end
        @(negedge clk);
        chk("bp_diff_end", 64'(bus.diff), 64'(8'h87));
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 64'(bus.out_valid), 64'(0));
        chk("bp_release_in_ready",  64'(bus.in_ready),  64'(1));

        // Reset on the third BUSY cycle; the in-flight op must never complete
        issue(8'h44, 8'h22, 1'b0, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_in_ready",  64'(bus.in_ready),  64'(0));
        chk("midrst_diff",      64'(bus.diff),      64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_after", 64'(bus.in_ready), 64'(1));
        issue(8'h10, 8'h20, 1'b1, '{diff: 8'hF0, bor: 1'b1, ovf: 1'b0, zero: 1'b0});

        // Back-to-back random ops; accepts should be W+2 cycles apart
        wait_idle();
        bad_gap = 0;
        prev = -1;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            e  = model(ra, rb);
            issue(ra, rb, 1'b1, e);
            if (prev >= 0 && (last_acc - prev) != W + 2) bad_gap++;
            prev = last_acc;
        end
        chk("throughput_bad_gaps", 64'(bad_gap), 64'(0));

        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
